quad_stream_sync_ctrl: RTL and testbench
========================================

Name: quad_stream_sync_ctrl

Overview:
- Sequences the four-input sample summer.
- Buffers four independent 256-bit AXI-Stream sources (16 x 16-bit samples each) in per-channel FIFOs.
- Releases one time-aligned beat from all enabled channels at once to the summer, and frames the output with tlast.
- Detects and recovers from inter-channel skew; reports frame/error status.

Parameters:
DATA_WIDTH, 256, bits per channel beat
FIFO_DEPTH, 4, entries per channel FIFO; power of 2, >=2
FRAME_LEN, 64, beats per output frame; >=1
SKEW_TIMEOUT, 255, cycles of partial-channel occupancy before skew error; >=1

Ports:
CLK  in  1  clock
resetn  in  1  synchronous active-low reset
s_axis_tdata  in  4*DATA_WIDTH  channel k at [k*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  in  4  per-channel valid
s_axis_tready  out  4  per-channel ready
ch_enable  in  4  requested channel mask
m_axis_tdata  out  4*DATA_WIDTH  aligned beat to summer, same packing as input
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  summer ready
m_axis_tlast  out  1  last beat of frame
frame_count  out  16  completed frames, wraps at 65535->0
skew_error  out  1  sticky skew fault
err_clear  in  1  clears skew_error

Behaviour:
- Reset (resetn=0 at CLK edge):
  - All FIFOs empty; s_axis_tready=0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0.
  - frame_count=0; skew_error=0; beat counter=0; skew counter=0; active_mask=4'b1111.
  - Reset mid-frame discards all buffered and in-flight beats.
- Input acceptance:
  - s_axis_tready[k] = !full[k], from registered FIFO count.
  - Push on tvalid&&tready.
  - Channel not in active_mask: tready=1; beats are dropped and never stored.
- Issue condition, evaluated every cycle:
  - active_mask != 0.
  - Every active channel's FIFO is non-empty.
  - Output register free: !m_axis_tvalid || m_axis_tready.
- Issue action:
  - Pop one entry from each active FIFO into the output register.
  - Inactive channel slices are loaded with 0.
  - m_axis_tvalid=1.
- Output register holds data, valid and last stable while tvalid && !tready.
- Latency: a beat pushed at edge N can appear at the output at edge N+1, i.e. visible in cycle N+1. Minimum is 2 cycles input-handshake-to-output-valid.
- Throughput: 1 beat/cycle sustained when all active sources stream and tready=1.
- Same-cycle push and pop on one FIFO: both occur, count unchanged. Full FIFO with same-cycle pop does not accept, because tready comes from the registered count.
- Framing:
  - Beat counter increments on each issue.
  - m_axis_tlast=1 on the issue where beat counter == FRAME_LEN-1; the counter then wraps to 0.
  - frame_count increments on the output handshake (tvalid&&tready) of a tlast beat.
- Mask update:
  - active_mask <= ch_enable only when beat counter == 0 and no issue occurs that cycle, or on the tlast issue cycle.
  - A mask change therefore never splits a frame.
  - A newly disabled channel's FIFO is flushed when the mask updates.
  - ch_enable == 0: no issues; all tready=1; data discarded.
- Skew watchdog:
  - Skew counter increments each cycle where at least one active FIFO is non-empty and at least one active FIFO is empty; otherwise it clears to 0.
  - When the counter reaches SKEW_TIMEOUT:
    - skew_error<=1.
    - All FIFOs flush.
    - Beat counter <= 0.
    - Skew counter <= 0.
  - The output register is not affected and completes its handshake normally.
  - A partial frame is not terminated with tlast; the next issued beat starts a new frame.
- err_clear clears skew_error. If set and clear occur in the same cycle, set wins.
- No arithmetic on sample data; widths are passed through unchanged. The summer owns sample growth.

Test Plan:
- Aligned streaming: all 4 channels enabled, ch k sends beats whose 16-bit samples = 0x0100*k + beat index, m_axis_tready=1, FRAME_LEN=4 -> first output 2 cycles after first input; tlast on beats 3,7,11; frame_count=3 after 12 beats; no bubbles.
- Backpressure: m_axis_tready=0 for 10 cycles mid-stream -> output beat held stable; each s_axis_tready drops after FIFO_DEPTH=4 more pushes; no beat lost or duplicated after release (scoreboard on index).
- Skew recovery: SKEW_TIMEOUT=8, ch0-2 send 1 beat, ch3 silent -> skew_error=1 exactly 8 cycles after the first partial cycle; FIFOs empty; err_clear pulse -> skew_error=0; realigned stream restarts at beat counter 0.
- Mask change: ch_enable 4'b1111 -> 4'b0101 asserted mid-frame (beat 1 of 4) -> current frame completes with all 4 channels; from the next frame, slices 1 and 3 = 0 and ch1/ch3 tready=1 with inputs dropped.
- Mask zero: ch_enable=0 -> m_axis_tvalid stays 0 over 50 cycles with all inputs valid; all tready=1.
- Reset mid-frame: resetn low 1 cycle at beat 2 with FIFOs holding 3 entries -> next cycle all outputs at reset values; frame_count=0; first post-reset beats form beat 0 of a new frame.

Source files
------------

// File: rtl/quad_stream_sync_ctrl.sv
// Four-channel AXI-Stream aligner feeding the sample summer.
// Per-channel FIFOs, lockstep issue, frame tagging and skew recovery.
module quad_stream_sync_ctrl #(
    parameter int DATA_WIDTH   = 256,
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_LEN    = 64,
    parameter int SKEW_TIMEOUT = 255
) (
    input  logic                    CLK,
    input  logic                    resetn,
    input  logic [4*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [3:0]              s_axis_tvalid,
    output logic [3:0]              s_axis_tready,
    input  logic [3:0]              ch_enable,
    output logic [4*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [15:0]             frame_count,
    output logic                    skew_error,
    input  logic                    err_clear
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam int SW = $clog2(SKEW_TIMEOUT + 1);

    logic [DATA_WIDTH-1:0]   mem [4][FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr [4];
    logic [AW-1:0]           rd_ptr [4];
    logic [CW-1:0]           cnt [4];
    logic [3:0]              full;
    logic [3:0]              empty;
    logic [3:0]              push;
    logic [3:0]              pop;
    logic [3:0]              flush;
    logic [3:0]              in_rdy;
    logic [3:0]              active_mask;
    logic [BW-1:0]           beat_cnt;
    logic [SW-1:0]           skew_cnt;
    logic                    issue;
    logic                    last_beat;
    logic                    mask_upd;
    logic                    partial;
    logic                    timeout;
    logic [4*DATA_WIDTH-1:0] nxt_data;

    always_comb begin
        full     = '0;
        empty    = '0;
        nxt_data = '0;
        for (int k = 0; k < 4; k++) begin
            full[k]  = (cnt[k] == CW'(FIFO_DEPTH));
            empty[k] = (cnt[k] == '0);
            if (active_mask[k])
                nxt_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[k][rd_ptr[k]];
        end
        issue = (active_mask != '0)
              && ((active_mask & empty) == '0)
              && (!m_axis_tvalid || m_axis_tready);
        last_beat = (beat_cnt == BW'(FRAME_LEN - 1));
        // Mask only moves on frame boundaries so a frame is never split
        mask_upd = ((beat_cnt == '0) && !issue) || (issue && last_beat);
        partial  = ((active_mask & ~empty) != '0)
                 && ((active_mask & empty) != '0);
        timeout  = partial && (skew_cnt == SW'(SKEW_TIMEOUT - 1));
        if (timeout)
            flush = 4'hF;
        else if (mask_upd)
            flush = active_mask & ~ch_enable;
        else
            flush = '0;
        s_axis_tready = in_rdy & (~active_mask | ~full);
        push = s_axis_tvalid & s_axis_tready & active_mask;
        pop  = issue ? active_mask : 4'h0;
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < 4; k++)
            if (push[k])
                mem[k][wr_ptr[k]] <= s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (flush[k]) begin
                    wr_ptr[k] <= '0;
                    rd_ptr[k] <= '0;
                    cnt[k]    <= '0;
                end else begin
                    if (push[k])
                        wr_ptr[k] <= wr_ptr[k] + AW'(1);
                    if (pop[k])
                        rd_ptr[k] <= rd_ptr[k] + AW'(1);
                    if (push[k] && !pop[k])
                        cnt[k] <= cnt[k] + CW'(1);
                    else if (!push[k] && pop[k])
                        cnt[k] <= cnt[k] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (issue) begin
            m_axis_tdata  <= nxt_data;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last_beat;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            beat_cnt    <= '0;
            skew_cnt    <= '0;
            skew_error  <= 1'b0;
            frame_count <= '0;
            active_mask <= 4'hF;
            in_rdy      <= 4'h0;
        end else begin
            in_rdy <= 4'hF;
            if (timeout)
                beat_cnt <= '0;
            else if (issue)
                beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
            if (timeout || !partial)
                skew_cnt <= '0;
            else
                skew_cnt <= skew_cnt + SW'(1);
            if (timeout)
                skew_error <= 1'b1;
            else if (err_clear)
                skew_error <= 1'b0;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                frame_count <= frame_count + 16'd1;
            if (mask_upd)
                active_mask <= ch_enable;
        end
    end

endmodule

// File: tb/tb_quad_stream_sync_ctrl.sv
// Directed bench for quad_stream_sync_ctrl.
// Per-channel sources, output scoreboard, hand-computed frame counts.
module tb_quad_stream_sync_ctrl;

    localparam int DW = 256;

    logic            CLK = 1'b0;
    logic            resetn = 1'b0;
    logic [4*DW-1:0] s_axis_tdata = '0;
    logic [3:0]      s_axis_tvalid = '0;
    logic [3:0]      s_axis_tready;
    logic [3:0]      ch_enable = 4'hF;
    logic [4*DW-1:0] m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic [15:0]     frame_count;
    logic            skew_error;
    logic            err_clear = 1'b0;

    quad_stream_sync_ctrl #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (4),
        .FRAME_LEN   (4),
        .SKEW_TIMEOUT(8)
    ) dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .ch_enable    (ch_enable),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .frame_count  (frame_count),
        .skew_error   (skew_error),
        .err_clear    (err_clear)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int smp = 0;
    int nout = 0;
    int out_beat = 0;
    int first_in = -1;
    int first_out = -1;
    int last_out = -1;
    int in_idx [4] = '{0, 0, 0, 0};
    int out_idx [4] = '{0, 0, 0, 0};
    int lim [4] = '{0, 0, 0, 0};
    logic [3:0] exp_mask = 4'hF;
    logic [3:0] exp_next = 4'hF;
    logic rst_q = 1'b0;
    logic rdy_q = 1'b1;
    logic clr_q = 1'b0;
    logic [3:0] en_q = 4'hF;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] beat(input int k, input int idx);
        logic [15:0] s;
        s = 16'(k * 256 + idx);
        return {16{s}};
    endfunction

    task automatic tick();
        logic lst;
        @(posedge CLK);
        #1;
        resetn        = rst_q;
        ch_enable     = en_q;
        m_axis_tready = rdy_q;
        err_clear     = clr_q;
        for (int k = 0; k < 4; k++) begin
            s_axis_tvalid[k] = (in_idx[k] < lim[k]);
            s_axis_tdata[k*DW +: DW] = beat(k, in_idx[k]);
        end
        @(negedge CLK);
        smp++;
        for (int k = 0; k < 4; k++)
            if (s_axis_tvalid[k] && s_axis_tready[k]) begin
                in_idx[k]++;
                if (first_in < 0)
                    first_in = smp;
            end
        if (m_axis_tvalid && first_out < 0)
            first_out = smp;
        if (m_axis_tvalid && m_axis_tready) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("data%0d", k), m_axis_tdata[k*DW +: DW],
                      exp_mask[k] ? beat(k, out_idx[k]) : 256'd0);
                if (exp_mask[k])
                    out_idx[k]++;
            end
            lst = (out_beat == 3);
            check("tlast", 256'(m_axis_tlast), 256'(lst));
            out_beat = lst ? 0 : out_beat + 1;
            if (lst)
                exp_mask = exp_next;
            nout++;
            last_out = smp;
        end
    endtask

    task automatic add_all(input int n);
        for (int k = 0; k < 4; k++)
            lim[k] = in_idx[k] + n;
    endtask

    initial begin
        int n0;
        int vcnt;
        logic [255:0] held;

        // reset state
        repeat (2) tick();
        check("rst_valid", 256'(m_axis_tvalid), 256'd0);
        check("rst_last", 256'(m_axis_tlast), 256'd0);
        check("rst_data", m_axis_tdata[DW-1:0], 256'd0);
        check("rst_frames", 256'(frame_count), 256'd0);
        check("rst_err", 256'(skew_error), 256'd0);
        check("rst_ready", 256'(s_axis_tready), 256'd0);

        // aligned streaming, three frames
        rst_q = 1'b1;
        add_all(12);
        repeat (20) tick();
        check("t1_beats", 256'(nout), 256'd12);
        check("t1_latency", 256'(first_out - first_in), 256'd2);
        check("t1_nobubble", 256'(last_out - first_out), 256'd11);
        check("t1_frames", 256'(frame_count), 256'd3);

        // backpressure for ten cycles mid-stream
        n0 = nout;
        add_all(16);
        repeat (4) tick();
        rdy_q = 1'b0;
        tick();
        check("t2_hold_v0", 256'(m_axis_tvalid), 256'd1);
        held = m_axis_tdata[DW-1:0];
        repeat (9) tick();
        check("t2_hold_d", m_axis_tdata[DW-1:0], held);
        check("t2_hold_v", 256'(m_axis_tvalid), 256'd1);
        check("t2_full", 256'(s_axis_tready), 256'd0);
        rdy_q = 1'b1;
        repeat (30) tick();
        check("t2_beats", 256'(nout - n0), 256'd16);
        check("t2_frames", 256'(frame_count), 256'd7);

        // skew: ch0-2 send one beat, ch3 silent
        for (int k = 0; k < 3; k++)
            lim[k] = in_idx[k] + 1;
        repeat (9) tick();
        check("t3_err_early", 256'(skew_error), 256'd0);
        tick();
        check("t3_err_set", 256'(skew_error), 256'd1);
        check("t3_no_out", 256'(m_axis_tvalid), 256'd0);
        for (int k = 0; k < 4; k++)
            out_idx[k] = in_idx[k];
        clr_q = 1'b1;
        tick();
        clr_q = 1'b0;
        tick();
        check("t3_err_clr", 256'(skew_error), 256'd0);
        n0 = nout;
        add_all(4);
        repeat (12) tick();
        check("t3_beats", 256'(nout - n0), 256'd4);
        check("t3_frames", 256'(frame_count), 256'd8);

        // mask change during beat 1 of a frame
        n0 = nout;
        add_all(8);
        repeat (2) tick();
        en_q = 4'b0101;
        exp_next = 4'b0101;
        repeat (20) tick();
        check("t4_beats", 256'(nout - n0), 256'd8);
        check("t4_frames", 256'(frame_count), 256'd10);
        check("t4_rdy_dis", 256'(s_axis_tready & 4'b1010), 256'd10);

        // mask zero: nothing issued, everything accepted
        en_q = 4'h0;
        add_all(100);
        vcnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m_axis_tvalid)
                vcnt++;
        end
        check("t5_novalid", 256'(vcnt), 256'd0);
        check("t5_ready", 256'(s_axis_tready), 256'hF);
        add_all(0);

        // reset mid-frame with beats buffered
        en_q = 4'hF;
        exp_next = 4'hF;
        exp_mask = 4'hF;
        repeat (2) tick();
        rdy_q = 1'b0;
        add_all(4);
        repeat (8) tick();
        check("t6_pre_v", 256'(m_axis_tvalid), 256'd1);
        rst_q = 1'b0;
        tick();
        rst_q = 1'b1;
        tick();
        check("t6_valid", 256'(m_axis_tvalid), 256'd0);
        check("t6_last", 256'(m_axis_tlast), 256'd0);
        check("t6_data", m_axis_tdata[DW-1:0], 256'd0);
        check("t6_frames", 256'(frame_count), 256'd0);
        check("t6_ready", 256'(s_axis_tready), 256'd0);
        for (int k = 0; k < 4; k++)
            out_idx[k] = in_idx[k];
        out_beat = 0;
        rdy_q = 1'b1;
        n0 = nout;
        add_all(4);
        repeat (10) tick();
        check("t6_beats", 256'(nout - n0), 256'd4);
        check("t6_frames2", 256'(frame_count), 256'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
